// File: rtl/pulse_stretch.sv
// Event shaper: replays each single-cycle strobe as a HIGH_CYC-long level followed by
// at least GAP_CYC low cycles, queueing overlapping events in a saturating counter.
module pulse_stretch #(
    parameter int HIGH_CYC = 4,
    parameter int GAP_CYC  = 4,
    parameter int CNT_W    = 4
) (
    input  logic             clk_src,
    input  logic             rst,
    input  logic             evt_in,
    input  logic             clr_ovf,
    output logic             pulse_out,
    output logic             busy,
    output logic [CNT_W-1:0] pending,
    output logic             overflow
);

    localparam int MAX_CYC = (HIGH_CYC > GAP_CYC) ? HIGH_CYC : GAP_CYC;
    localparam int PH_W    = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        GAP
    } state_t;

    state_t           state_q, state_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic [CNT_W-1:0] pending_q, pending_d;
    logic             overflow_q, overflow_d;
    logic             pulse_q, pulse_d;

    logic last_high, last_gap, start, full, drop, acc;

    always_comb begin
        last_high = (state_q == HIGH) && (phase_q == PH_W'(HIGH_CYC - 1));
        last_gap  = (state_q == GAP)  && (phase_q == PH_W'(GAP_CYC - 1));
        start     = ((state_q == IDLE) || last_gap) && ((pending_q != '0) || evt_in);
        full      = (pending_q == '1);
        drop      = evt_in && full && !start;
        acc       = evt_in && !drop;
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q + PH_W'(1);
        if (start) begin
            state_d = HIGH;
            phase_d = '0;
        end else begin
            case (state_q)
                IDLE: phase_d = '0;
                HIGH: begin
                    if (last_high) begin
                        state_d = GAP;
                        phase_d = '0;
                    end
                end
                GAP: begin
                    if (last_gap) begin
                        state_d = IDLE;
                        phase_d = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    phase_d = '0;
                end
            endcase
        end
    end

    // A direct-consumed event (acc and start together) leaves the count unchanged,
    // which also covers accepting at saturation when a pulse starts.
    always_comb begin
        pending_d = pending_q;
        case ({acc, start})
            2'b10:   pending_d = pending_q + CNT_W'(1);
            2'b01:   pending_d = pending_q - CNT_W'(1);
            default: pending_d = pending_q;
        endcase
    end

    always_comb begin
        overflow_d = overflow_q;
        if (drop)
            overflow_d = 1'b1;
        else if (clr_ovf)
            overflow_d = 1'b0;
        pulse_d = (state_d == HIGH);
    end

    always_ff @(posedge clk_src) begin
        if (rst) begin
            state_q    <= IDLE;
            phase_q    <= '0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
            pulse_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            pulse_q    <= pulse_d;
        end
    end

    assign pulse_out = pulse_q;
    assign pending   = pending_q;
    assign overflow  = overflow_q;
    assign busy      = (state_q != IDLE) || (pending_q != '0);

endmodule

// File: tb/tb_pulse_stretch.sv
// Directed bench for pulse_stretch: default instance A and a CNT_W=2 instance B
// for saturation behaviour. Cycle c counts clocks after the first event cycle.
module tb_pulse_stretch;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_evt, a_clr;
    logic       a_pulse, a_busy, a_ovf;
    logic [3:0] a_pend;
    logic       b_evt, b_clr;
    logic       b_pulse, b_busy, b_ovf;
    logic [1:0] b_pend;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pulse_stretch #(.HIGH_CYC(4), .GAP_CYC(4), .CNT_W(4)) dut_a (
        .clk_src(clk), .rst(rst), .evt_in(a_evt), .clr_ovf(a_clr),
        .pulse_out(a_pulse), .busy(a_busy), .pending(a_pend), .overflow(a_ovf)
    );

    pulse_stretch #(.HIGH_CYC(4), .GAP_CYC(4), .CNT_W(2)) dut_b (
        .clk_src(clk), .rst(rst), .evt_in(b_evt), .clr_ovf(b_clr),
        .pulse_out(b_pulse), .busy(b_busy), .pending(b_pend), .overflow(b_ovf)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks++;
        if ({a_pulse, a_busy, a_pend, a_ovf} !== 7'b0) begin
            errors++;
            $display("FAIL reset_a: got pulse=%b busy=%b pend=%0d ovf=%b, want all 0",
                     a_pulse, a_busy, a_pend, a_ovf);
        end
        checks++;
        if ({b_pulse, b_busy, b_pend, b_ovf} !== 5'b0) begin
            errors++;
            $display("FAIL reset_b: got pulse=%b busy=%b pend=%0d ovf=%b, want all 0",
                     b_pulse, b_busy, b_pend, b_ovf);
        end
        step();
    endtask

    task automatic test_single();
        logic ep, eb;
        a_evt = 1'b1;
        step();
        a_evt = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            ep = (c <= 4);
            eb = (c <= 8);
            checks++;
            if (a_pulse !== ep || a_busy !== eb || a_pend !== 4'd0) begin
                errors++;
                $display("FAIL single c=%0d: got pulse=%b busy=%b pend=%0d, want pulse=%b busy=%b pend=0",
                         c, a_pulse, a_busy, a_pend, ep, eb);
            end
            step();
        end
    endtask

    task automatic test_burst();
        logic       ep, eb;
        logic [3:0] en;
        a_evt = 1'b1;
        step();
        step();
        step();
        a_evt = 1'b0;
        for (int c = 3; c <= 26; c++) begin
            ep = (c <= 4) || (c >= 9 && c <= 12) || (c >= 17 && c <= 20);
            eb = (c <= 24);
            en = (c <= 8) ? 4'd2 : (c <= 16) ? 4'd1 : 4'd0;
            checks++;
            if (a_pulse !== ep || a_busy !== eb || a_pend !== en) begin
                errors++;
                $display("FAIL burst c=%0d: got pulse=%b busy=%b pend=%0d, want pulse=%b busy=%b pend=%0d",
                         c, a_pulse, a_busy, a_pend, ep, eb, en);
            end
            step();
        end
    endtask

    task automatic test_overflow();
        logic [1:0] en;
        logic       eo, prev;
        int         rises;
        rises = 0;
        prev  = b_pulse;
        b_evt = 1'b1;
        step();
        for (int c = 1; c <= 40; c++) begin
            b_evt = (c <= 5);
            en = (c <= 1) ? 2'd0 : (c == 2) ? 2'd1 : (c == 3) ? 2'd2 :
                 (c <= 8) ? 2'd3 : (c <= 16) ? 2'd2 : (c <= 24) ? 2'd1 : 2'd0;
            eo = (c >= 5);
            if (b_pulse && !prev) rises++;
            prev = b_pulse;
            checks++;
            if (b_pend !== en || b_ovf !== eo) begin
                errors++;
                $display("FAIL overflow c=%0d: got pend=%0d ovf=%b, want pend=%0d ovf=%b",
                         c, b_pend, b_ovf, en, eo);
            end
            step();
        end
        checks++;
        if (rises !== 4 || b_busy !== 1'b0) begin
            errors++;
            $display("FAIL overflow_pulses: got %0d pulses busy=%b, want 4 pulses busy=0", rises, b_busy);
        end
        b_clr = 1'b1;
        step();
        b_clr = 1'b0;
        checks++;
        if (b_ovf !== 1'b0) begin
            errors++;
            $display("FAIL clr_ovf: got ovf=%b, want 0", b_ovf);
        end
    endtask

    task automatic test_drop_clr();
        b_evt = 1'b1;
        step();
        step();
        step();
        step();
        checks++;
        if (b_pend !== 2'd3 || b_ovf !== 1'b0) begin
            errors++;
            $display("FAIL drop_clr_fill: got pend=%0d ovf=%b, want pend=3 ovf=0", b_pend, b_ovf);
        end
        b_clr = 1'b1;
        step();
        b_evt = 1'b0;
        b_clr = 1'b0;
        checks++;
        if (b_ovf !== 1'b1 || b_pend !== 2'd3) begin
            errors++;
            $display("FAIL drop_clr_same: got ovf=%b pend=%0d, want ovf=1 pend=3", b_ovf, b_pend);
        end
        for (int c = 0; c < 40; c++) step();
        checks++;
        if (b_busy !== 1'b0 || b_ovf !== 1'b1) begin
            errors++;
            $display("FAIL drop_clr_drain: got busy=%b ovf=%b, want busy=0 ovf=1", b_busy, b_ovf);
        end
    endtask

    task automatic test_back_to_back();
        logic ep;
        a_evt = 1'b1;
        step();
        a_evt = 1'b0;
        for (int c = 1; c <= 18; c++) begin
            ep = (c <= 4) || (c >= 9 && c <= 12);
            checks++;
            if (a_pulse !== ep || a_pend !== 4'd0) begin
                errors++;
                $display("FAIL coincident c=%0d: got pulse=%b pend=%0d, want pulse=%b pend=0",
                         c, a_pulse, a_pend, ep);
            end
            a_evt = (c == 8);
            step();
        end
        a_evt = 1'b0;
    endtask

    task automatic test_reset_mid();
        a_evt = 1'b1;
        step();
        step();
        step();
        a_evt = 1'b0;
        checks++;
        if (a_pulse !== 1'b1 || a_pend !== 4'd2) begin
            errors++;
            $display("FAIL reset_mid_pre: got pulse=%b pend=%0d, want pulse=1 pend=2", a_pulse, a_pend);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int c = 4; c <= 24; c++) begin
            checks++;
            if (a_pulse !== 1'b0 || a_pend !== 4'd0 || a_busy !== 1'b0 || a_ovf !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid c=%0d: got pulse=%b pend=%0d busy=%b ovf=%b, want all 0",
                         c, a_pulse, a_pend, a_busy, a_ovf);
            end
            step();
        end
    endtask

    initial begin
        rst   = 1'b0;
        a_evt = 1'b0;
        a_clr = 1'b0;
        b_evt = 1'b0;
        b_clr = 1'b0;
        test_reset();
        test_single();
        test_burst();
        test_back_to_back();
        test_overflow();
        test_drop_clr();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
